// File: rtl/bfseq_pkg.sv
// Shared constants and types for the butterfly microcode sequencer.
package bfseq_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam logic [3:0] FIRST_GPR = 4'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dest;
  } slot_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/bfseq_decode.sv
// Combinational instruction decode: slot split, write enables and illegal-program detection.
module bfseq_decode
  import bfseq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  op1,
  output logic [3:0]  op2,
  output logic [3:0]  src1a,
  output logic [3:0]  src1b,
  output logic [3:0]  src2a,
  output logic [3:0]  src2b,
  output logic [3:0]  dest1,
  output logic [3:0]  dest2,
  output logic        halt,
  output logic        we1,
  output logic        we2,
  output logic        illegal
);

  slot_t s1, s2;
  logic  alu1, alu2, halt2, bad1, bad2, same_dest, raw;

  // A slot-1 HALT turns the whole instruction into a stop; slot 2 is then ignored.
  always_comb begin
    s1        = slot_t'(instr[31:16]);
    s2        = slot_t'(instr[15:0]);
    halt      = (s1.op == OP_HALT);
    alu1      = !halt && is_alu_op(s1.op);
    alu2      = !halt && is_alu_op(s2.op);
    halt2     = !halt && (s2.op == OP_HALT);
    bad1      = alu1 && (s1.dest < FIRST_GPR);
    bad2      = alu2 && (s2.dest < FIRST_GPR);
    same_dest = alu1 && alu2 && (s1.dest == s2.dest);
    raw       = alu1 && alu2 && ((s2.src_a == s1.dest) || (s2.src_b == s1.dest));
    we1       = alu1 && !bad1;
    we2       = alu2 && !bad2 && !same_dest;
    illegal   = bad1 || bad2 || same_dest || raw || halt2;
    op1       = alu1 ? s1.op : OP_NOP;
    op2       = alu2 ? s2.op : OP_NOP;
    src1a     = s1.src_a;
    src1b     = s1.src_b;
    src2a     = s2.src_a;
    src2b     = s2.src_b;
    dest1     = s1.dest;
    dest2     = s2.dest;
  end

endmodule

// File: rtl/bfseq_ctrl.sv
// bfseq_ctrl: microcode sequencer driving the butterfly dual-port register file.
// Define BFSEQ_CYCLE_CNT_EN to add the saturating busy-cycle counter output 'cycles'.
module bfseq_ctrl
  import bfseq_pkg::*;
#(
  parameter int  N          = 8,
  parameter int  PROG_DEPTH = 32,
  parameter int  ALU_LAT    = 1,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_data,
  output logic [3:0]    R1addr1,
  output logic [3:0]    R1addr2,
  output logic [3:0]    R1addr3,
  output logic [3:0]    R2addr1,
  output logic [3:0]    R2addr2,
  output logic [3:0]    R2addr3,
  output logic [3:0]    op1,
  output logic [3:0]    op2,
  output logic          w1,
  output logic          w2
`ifdef BFSEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]   cycles
`endif
);

  localparam int unsigned   LW       = $clog2(ALU_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);
  localparam logic [AW-1:0] PC_LAST  = AW'(PROG_DEPTH - 1);

  if (N < 1 || ALU_LAT < 1 || PROG_DEPTH < 2) begin : g_bad_params
    $error("bfseq_ctrl: N, ALU_LAT must be >= 1 and PROG_DEPTH >= 2");
  end

  logic [2:0]    state;
  logic [AW-1:0] pc;
  logic [31:0]   ir;
  logic [LW-1:0] lat_cnt;
  logic [31:0]   cur_instr;
  logic [3:0]    d_op1, d_op2, d_s1a, d_s1b, d_s2a, d_s2b, d_d1, d_d2;
  logic          d_halt, d_we1, d_we2, d_illegal;
  logic          active;

  // During ISSUE the ROM word is decoded directly so sources appear that cycle.
  assign cur_instr = (state == ST_ISSUE) ? imem_data : ir;

  bfseq_decode u_decode (
    .instr   (cur_instr),
    .op1     (d_op1),
    .op2     (d_op2),
    .src1a   (d_s1a),
    .src1b   (d_s1b),
    .src2a   (d_s2a),
    .src2b   (d_s2b),
    .dest1   (d_d1),
    .dest2   (d_d2),
    .halt    (d_halt),
    .we1     (d_we1),
    .we2     (d_we2),
    .illegal (d_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      lat_cnt <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_FETCH;
          pc    <= '0;
          err   <= 1'b0;
        end
        ST_FETCH: state <= ST_ISSUE;
        ST_ISSUE: begin
          ir      <= imem_data;
          lat_cnt <= '0;
          if (d_illegal) err <= 1'b1;
          state   <= d_halt ? ST_DONE : ST_EXEC;
        end
        ST_EXEC: begin
          if (lat_cnt == LAT_LAST) state <= ST_WB;
          else lat_cnt <= lat_cnt + LW'(1);
        end
        // The last ROM word finishes the program instead of wrapping pc.
        ST_WB: begin
          if (pc == PC_LAST) begin
            state <= ST_DONE;
          end else begin
            pc    <= pc + AW'(1);
            state <= ST_FETCH;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign active    = (state == ST_ISSUE) || (state == ST_EXEC) || (state == ST_WB);
  assign busy      = (state == ST_FETCH) || active;
  assign done      = (state == ST_DONE);
  assign imem_addr = pc;

  always_comb begin
    R1addr1 = '0;
    R1addr2 = '0;
    R1addr3 = '0;
    R2addr1 = '0;
    R2addr2 = '0;
    R2addr3 = '0;
    op1     = '0;
    op2     = '0;
    w1      = 1'b0;
    w2      = 1'b0;
    if (active) begin
      R1addr1 = d_s1a;
      R1addr2 = d_s1b;
      R2addr1 = d_s2a;
      R2addr2 = d_s2b;
      op1     = d_op1;
      op2     = d_op2;
    end
    if (state == ST_WB) begin
      R1addr3 = d_d1;
      R2addr3 = d_d2;
      w1      = d_we1;
      w2      = d_we2;
    end
  end

`ifdef BFSEQ_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycles <= '0;
    else if (state == ST_IDLE && start) cycles <= '0;
    else if (busy && cycles != 16'hFFFF) cycles <= cycles + 16'd1;
  end
`endif

endmodule
